stream_width_upsizer: RTL and testbench



---
 rtl/stream_width_upsizer.sv | 85 ++++++++
 tb/tb_stream_width_upsizer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_width_upsizer.sv
// Narrow-to-wide stream packer: gathers RATIO beats of IN_W bits into one
// little-endian OUT_W word, flushing a partial word early on s_last.
module stream_width_upsizer #(
    parameter int IN_W  = 8,
    parameter int RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IN_W-1:0]         s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [IN_W*RATIO-1:0]   m_data,
    output logic [RATIO-1:0]        m_keep,
    output logic                    m_last
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] acc;
    logic [RATIO-1:0] acc_keep;

    logic             accept;
    logic             completing;
    logic [OUT_W-1:0] word_next;
    logic [RATIO-1:0] keep_next;

    // The output register can take a new word whenever it is empty or draining.
    assign s_ready    = !m_valid || m_ready;
    assign accept     = s_valid && s_ready;
    assign completing = accept && ((cnt == LAST_LANE) || s_last);

    // Lanes below cnt come from the accumulator, lane cnt from the incoming
    // beat, and everything above is forced to zero.
    always_comb begin
        word_next = '0;
        keep_next = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (k < int'(cnt)) begin
                word_next[k*IN_W +: IN_W] = acc[k*IN_W +: IN_W];
                keep_next[k]              = acc_keep[k];
            end else if (k == int'(cnt)) begin
                word_next[k*IN_W +: IN_W] = s_data;
                keep_next[k]              = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            acc_keep <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_keep   <= '0;
            m_last   <= 1'b0;
        end else if (completing) begin
            m_data   <= word_next;
            m_keep   <= keep_next;
            m_last   <= s_last;
            m_valid  <= 1'b1;
            cnt      <= '0;
            acc      <= '0;
            acc_keep <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < RATIO; k++) begin
                    if (k == int'(cnt)) begin
                        acc[k*IN_W +: IN_W] <= s_data;
                        acc_keep[k]         <= 1'b1;
                    end
                end
                cnt <= cnt + CNT_W'(1);
            end
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_width_upsizer.sv
// Bench for stream_width_upsizer: directed vectors on an 8->16 instance and a
// randomised valid/ready run on an 8->32 instance, both scoreboarded.
module tb_stream_width_upsizer;
    // Handshake: a beat moves on a rising edge where s_valid && s_ready, a word
    // moves on a rising edge where m_valid && m_ready; inputs change at posedge+1.
    localparam int WA = 16 + 2 + 1;
    localparam int WB = 32 + 4 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_s_valid = 1'b0, a_s_ready, a_s_last = 1'b0;
    logic [7:0]  a_s_data = 8'h00;
    logic        a_m_valid, a_m_ready = 1'b1, a_m_last;
    logic [15:0] a_m_data;
    logic [1:0]  a_m_keep;

    logic        b_s_valid = 1'b0, b_s_ready, b_s_last = 1'b0;
    logic [7:0]  b_s_data = 8'h00;
    logic        b_m_valid, b_m_ready = 1'b1, b_m_last;
    logic [31:0] b_m_data;
    logic [3:0]  b_m_keep;
    logic        b_rand_en = 1'b0;

    logic [WA-1:0] exp_a_q[$];
    logic [WB-1:0] exp_b_q[$];

    int total = 0;
    int bad   = 0;

    stream_width_upsizer #(.IN_W(8), .RATIO(2)) dut_a (
        .clk(clk), .rst(rst),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_last(a_s_last),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_keep(a_m_keep),
        .m_last(a_m_last)
    );

    stream_width_upsizer #(.IN_W(8), .RATIO(4)) dut_b (
        .clk(clk), .rst(rst),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_keep(b_m_keep),
        .m_last(b_m_last)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drivers
    task automatic push_a(input logic [15:0] d, input logic [1:0] k, input logic l);
        exp_a_q.push_back({d, k, l});
    endtask

    task automatic send_a(input logic [7:0] d, input logic l, output int waits, output logic mv_seen);
        logic hs;
        hs = 1'b0;
        waits = 0;
        mv_seen = 1'b0;
        a_s_valid = 1'b1;
        a_s_data  = d;
        a_s_last  = l;
        while (!hs) begin
            @(negedge clk);
            hs = a_s_ready;
            if (waits == 0) mv_seen = a_m_valid;
            @(posedge clk);
            #1;
            if (!hs) begin
                waits++;
                if (waits > 50) begin
                    total++;
                    bad++;
                    $display("FAIL a_send_timeout: got no s_ready expected accept of %0h", d);
                    break;
                end
            end
        end
        a_s_valid = 1'b0;
        a_s_data  = 8'hEE;
        a_s_last  = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic l);
        logic hs;
        int waits;
        hs = 1'b0;
        waits = 0;
        b_s_valid = 1'b1;
        b_s_data  = d;
        b_s_last  = l;
        while (!hs) begin
            @(negedge clk);
            hs = b_s_ready;
            @(posedge clk);
            #1;
            if (!hs) begin
                waits++;
                if (waits > 50) begin
                    total++;
                    bad++;
                    $display("FAIL b_send_timeout: got no s_ready expected accept of %0h", d);
                    break;
                end
            end
        end
        b_s_valid = 1'b0;
        b_s_data  = 8'h5A;
        b_s_last  = 1'b0;
    endtask

    // Scoreboard monitors: a word is checked on the negedge before the edge that moves it.
    always @(negedge clk) begin
        if (!rst && a_m_valid && a_m_ready) begin
            if (exp_a_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_word: got %0h expected none", a_m_data);
            end else begin
                check("a_word", 64'({a_m_data, a_m_keep, a_m_last}), 64'(exp_a_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_m_valid && b_m_ready) begin
            if (exp_b_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_word: got %0h expected none", b_m_data);
            end else begin
                check("b_word", 64'({b_m_data, b_m_keep, b_m_last}), 64'(exp_b_q.pop_front()));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            b_m_ready = b_rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        int w;
        logic mv;
        int lane;
        logic [31:0] acc;
        logic [3:0] kp;
        logic [7:0] d;
        logic l;
        int budget;

        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", 64'(a_m_valid), 64'(0));
        check("rst_m_data", 64'(a_m_data), 64'(0));
        check("rst_m_keep", 64'(a_m_keep), 64'(0));
        check("rst_m_last", 64'(a_m_last), 64'(0));
        check("rst_s_ready", 64'(a_s_ready), 64'(1));
        @(posedge clk);
        #1;

        // Basic pack
        push_a(16'h2211, 2'b11, 1'b1);
        send_a(8'h11, 1'b0, w, mv);
        send_a(8'h22, 1'b1, w, mv);
        @(negedge clk);
        check("basic_latency_valid", 64'(a_m_valid), 64'(1));
        @(posedge clk);
        #1;

        // Full-rate streaming
        push_a(16'h0201, 2'b11, 1'b0);
        push_a(16'h0403, 2'b11, 1'b0);
        push_a(16'h0605, 2'b11, 1'b0);
        push_a(16'h0807, 2'b11, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            send_a(8'(i), (i == 8), w, mv);
            check("stream_s_ready", 64'(w), 64'(0));
            if (i > 1) check("stream_m_valid_cadence", 64'(mv), 64'(((i - 1) % 2) == 0));
        end
        @(negedge clk);
        check("stream_final_valid", 64'(a_m_valid), 64'(1));
        @(posedge clk);
        #1;

        // Partial flush
        push_a(16'h00AA, 2'b01, 1'b1);
        push_a(16'hCCBB, 2'b11, 1'b1);
        send_a(8'hAA, 1'b1, w, mv);
        send_a(8'hBB, 1'b0, w, mv);
        send_a(8'hCC, 1'b1, w, mv);
        cyc(2);

        // Backpressure
        a_m_ready = 1'b0;
        push_a(16'h2211, 2'b11, 1'b0);
        push_a(16'h4433, 2'b11, 1'b1);
        send_a(8'h11, 1'b0, w, mv);
        send_a(8'h22, 1'b0, w, mv);
        a_s_valid = 1'b1;
        a_s_data  = 8'h33;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_m_valid", 64'(a_m_valid), 64'(1));
            check("hold_m_data", 64'(a_m_data), 64'(16'h2211));
            check("hold_m_keep", 64'(a_m_keep), 64'(2'b11));
            check("hold_s_ready", 64'(a_s_ready), 64'(0));
            @(posedge clk);
            #1;
        end
        a_m_ready = 1'b1;
        send_a(8'h33, 1'b0, w, mv);
        send_a(8'h44, 1'b1, w, mv);
        cyc(2);

        // Drain and complete on the same edge
        a_m_ready = 1'b0;
        push_a(16'h00A1, 2'b01, 1'b1);
        push_a(16'h00B2, 2'b01, 1'b1);
        send_a(8'hA1, 1'b1, w, mv);
        a_m_ready = 1'b1;
        send_a(8'hB2, 1'b1, w, mv);
        @(negedge clk);
        check("b2b_m_valid", 64'(a_m_valid), 64'(1));
        check("b2b_m_data", 64'(a_m_data), 64'(16'h00B2));
        @(posedge clk);
        #1;

        // Reset mid-word
        send_a(8'h55, 1'b0, w, mv);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_m_valid", 64'(a_m_valid), 64'(0));
        check("midrst_m_data", 64'(a_m_data), 64'(0));
        check("midrst_m_keep", 64'(a_m_keep), 64'(0));
        check("midrst_m_last", 64'(a_m_last), 64'(0));
        check("midrst_s_ready", 64'(a_s_ready), 64'(1));
        @(posedge clk);
        #1;
        push_a(16'h7766, 2'b11, 1'b1);
        send_a(8'h66, 1'b0, w, mv);
        send_a(8'h77, 1'b1, w, mv);
        cyc(2);

        // RATIO=4 randomised valid/ready
        b_rand_en = 1'b1;
        lane = 0;
        acc = '0;
        kp = '0;
        for (int n = 0; n < 150; n++) begin
            d = 8'($urandom_range(0, 255));
            l = (n == 149) || ($urandom_range(0, 4) == 0);
            acc[lane*8 +: 8] = d;
            kp[lane] = 1'b1;
            if (l || lane == 3) begin
                exp_b_q.push_back({acc, kp, l});
                acc = '0;
                kp = '0;
                lane = 0;
            end else begin
                lane++;
            end
            if ($urandom_range(0, 2) == 0) cyc($urandom_range(1, 2));
            send_b(d, l);
        end
        b_rand_en = 1'b0;

        budget = 0;
        while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && budget < 200) begin
            cyc(1);
            budget++;
        end
        check("a_queue_empty", 64'(exp_a_q.size()), 64'(0));
        check("b_queue_empty", 64'(exp_b_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
